stack_alu_ctrl: RTL and testbench



---
 rtl/stack_alu_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_stack_alu_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_alu_ctrl.sv
// stack_alu_ctrl: command-driven RPN controller for an external 8-entry byte LIFO.
// Turns each accepted command into push/pop strobes, combines popped operands
// in an 8-bit ALU and pushes arithmetic results back onto the stack.
module stack_alu_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [7:0]    cmd_data,
  output logic          stk_wn,
  output logic          stk_rn,
  output logic [7:0]    stk_din,
  input  logic [7:0]    stk_dout,
  input  logic          stk_full,
  input  logic          stk_empty,
  output logic          res_valid,
  output logic [7:0]    res_data,
  output logic          err,
  output logic [CW-1:0] depth
);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_POP  = 3'd6;
  localparam logic [2:0] OP_DUP  = 3'd7;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] TWO     = CW'(2);

  typedef enum logic [2:0] {
    IDLE,
    POP_B,
    WAIT_B,
    POP_A,
    WAIT_A,
    PUSH
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [2:0]  op_q;
  logic [7:0]  data_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        second_q;
  logic        legal;
  logic        accept;
  logic [7:0]  alu_r;

  assign accept = cmd_valid && cmd_ready;

  // Decide whether the offered command fits the current stack occupancy.
  always_comb begin
    legal = 1'b0;
    case (cmd_op)
      OP_PUSH: legal = (depth < DEPTH_C);
      OP_POP:  legal = (depth >= ONE);
      OP_DUP:  legal = (depth >= ONE) && (depth < DEPTH_C);
      default: legal = (depth >= TWO);
    endcase
  end

  // ALU: A is the deeper operand, B the former top of stack; results wrap at 8 bits.
  always_comb begin
    alu_r = b_q;
    case (op_q)
      OP_ADD:  alu_r = a_q + b_q;
      OP_SUB:  alu_r = a_q - b_q;
      OP_AND:  alu_r = a_q & b_q;
      OP_OR:   alu_r = a_q | b_q;
      OP_XOR:  alu_r = a_q ^ b_q;
      default: alu_r = b_q;
    endcase
  end

  // Next-state and strobe generation; every strobe is a pure function of the state.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    stk_wn     = 1'b0;
    stk_rn     = 1'b0;
    stk_din    = 8'h00;
    res_valid  = 1'b0;
    res_data   = 8'h00;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && legal) begin
          next_state = (cmd_op == OP_PUSH) ? PUSH : POP_B;
        end
      end
      POP_B: begin
        stk_rn     = 1'b1;
        next_state = WAIT_B;
      end
      WAIT_B: begin
        if (op_q == OP_POP) begin
          res_valid  = 1'b1;
          res_data   = stk_dout;
          next_state = IDLE;
        end else if (op_q == OP_DUP) begin
          next_state = PUSH;
        end else begin
          next_state = POP_A;
        end
      end
      POP_A: begin
        stk_rn     = 1'b1;
        next_state = WAIT_A;
      end
      WAIT_A: begin
        next_state = PUSH;
      end
      PUSH: begin
        stk_wn = 1'b1;
        if (op_q == OP_PUSH) begin
          stk_din    = data_q;
          next_state = IDLE;
        end else if (op_q == OP_DUP) begin
          stk_din = b_q;
          if (second_q) begin
            res_valid  = 1'b1;
            res_data   = b_q;
            next_state = IDLE;
          end
        end else begin
          stk_din    = alu_r;
          res_valid  = 1'b1;
          res_data   = alu_r;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Command capture, operand latching and the DUP second-push flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_PUSH;
      data_q   <= 8'h00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      second_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
      end
      if (state == WAIT_B) begin
        b_q <= stk_dout;
      end
      if (state == WAIT_A) begin
        a_q <= stk_dout;
      end
      second_q <= (state == PUSH) && (op_q == OP_DUP) && !second_q;
    end
  end

  // Occupancy tracking and the sticky error flag (illegal command or LIFO flag disagreement).
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      err   <= 1'b0;
    end else begin
      if (stk_wn) begin
        depth <= depth + ONE;
      end else if (stk_rn) begin
        depth <= depth - ONE;
      end
      if ((accept && !legal) || (stk_wn && stk_full) || (stk_rn && stk_empty)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stack_alu_ctrl.sv
// tb_stack_alu_ctrl: directed bench for stack_alu_ctrl with an attached LIFO model
// and a transaction-level reference model checked every cycle.
module tb_stack_alu_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_POP  = 3'd6;
  localparam logic [2:0] OP_DUP  = 3'd7;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [7:0]    cmd_data;
  logic          stk_wn;
  logic          stk_rn;
  logic [7:0]    stk_din;
  logic [7:0]    stk_dout;
  logic          stk_full;
  logic          stk_empty;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          err;
  logic [CW-1:0] depth;

  logic          force_full;
  logic          force_empty;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_alu_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .stk_wn    (stk_wn),
    .stk_rn    (stk_rn),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err       (err),
    .depth     (depth)
  );

  // Attached LIFO: registered read data one cycle after a pop strobe.
  logic [7:0] mem [0:DEPTH-1];
  logic [3:0] lcnt;

  always @(posedge clk) begin
    if (rst) begin
      lcnt     <= 4'd0;
      stk_dout <= 8'h00;
    end else if (stk_wn) begin
      if (lcnt < 4'(DEPTH)) begin
        mem[lcnt[2:0]] <= stk_din;
        lcnt           <= lcnt + 4'd1;
      end
    end else if (stk_rn) begin
      if (lcnt > 4'd0) begin
        stk_dout <= mem[3'(lcnt - 4'd1)];
        lcnt     <= lcnt - 4'd1;
      end
    end
  end

  assign stk_full  = (lcnt == 4'(DEPTH)) || force_full;
  assign stk_empty = (lcnt == 4'd0) || force_empty;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected per-cycle strobes, generated at accept time from a byte stack.
  typedef struct {
    logic       wn;
    logic       rn;
    logic [7:0] din;
    logic       rv;
    logic [7:0] rd;
  } cyc_t;

  cyc_t       sched[$];
  logic [7:0] ms[$];
  int         exp_depth = 0;
  logic       exp_err   = 1'b0;
  bit         armed     = 1'b0;
  logic [7:0] last_res  = 8'h00;

  function automatic cyc_t mk(input logic wn, input logic rn, input logic [7:0] din,
                              input logic rv, input logic [7:0] rd);
    cyc_t c;
    c.wn = wn; c.rn = rn; c.din = din; c.rv = rv; c.rd = rd;
    return c;
  endfunction

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      OP_ADD:  r = int'(a) + int'(b);
      OP_SUB:  r = int'(a) - int'(b) + 256;
      OP_AND:  r = int'(a & b);
      OP_OR:   r = int'(a | b);
      default: r = int'(a ^ b);
    endcase
    return 8'(r % 256);
  endfunction

  // Compare DUT against the model mid-cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    cyc_t       rec;
    bit         has;
    bit         illegal;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    has = (sched.size() > 0);
    if (has) rec = sched.pop_front();
    else     rec = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    if (armed) begin
      checkOutput("cmd_ready", cmd_ready, !has);
      checkOutput("stk_wn", stk_wn, rec.wn);
      checkOutput("stk_rn", stk_rn, rec.rn);
      checkOutput("wn_rn_exclusive", stk_wn & stk_rn, 0);
      if (rec.wn) checkOutput("stk_din", stk_din, rec.din);
      checkOutput("res_valid", res_valid, rec.rv);
      if (rec.rv) checkOutput("res_data", res_data, rec.rd);
      checkOutput("err", err, exp_err);
      checkOutput("depth", depth, exp_depth);
      if ((rec.wn && stk_full) || (rec.rn && stk_empty)) exp_err = 1'b1;
    end
    if (res_valid) last_res = res_data;
    if (rec.wn) exp_depth++;
    if (rec.rn) exp_depth--;
    if (armed && !rst && !has && cmd_valid) begin
      illegal = 1'b0;
      case (cmd_op)
        OP_PUSH: begin
          if (ms.size() < DEPTH) begin
            sched.push_back(mk(1'b1, 1'b0, cmd_data, 1'b0, 8'h00));
            ms.push_back(cmd_data);
          end else illegal = 1'b1;
        end
        OP_POP: begin
          if (ms.size() >= 1) begin
            b = ms.pop_back();
            sched.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h00));
            sched.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, b));
          end else illegal = 1'b1;
        end
        OP_DUP: begin
          if (ms.size() >= 1 && ms.size() < DEPTH) begin
            b = ms[$];
            sched.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h00));
            sched.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
            sched.push_back(mk(1'b1, 1'b0, b, 1'b0, 8'h00));
            sched.push_back(mk(1'b1, 1'b0, b, 1'b1, b));
            ms.push_back(b);
          end else illegal = 1'b1;
        end
        default: begin
          if (ms.size() >= 2) begin
            b = ms.pop_back();
            a = ms.pop_back();
            r = alu(cmd_op, a, b);
            sched.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h00));
            sched.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
            sched.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h00));
            sched.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
            sched.push_back(mk(1'b1, 1'b0, r, 1'b1, r));
            ms.push_back(r);
          end else illegal = 1'b1;
        end
      endcase
      if (illegal) exp_err = 1'b1;
    end
    if (rst) begin
      sched.delete();
      ms.delete();
      exp_depth = 0;
      exp_err   = 1'b0;
      armed     = 1'b1;
    end
  end

  task automatic resetDut();
    @(posedge clk); #1;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Offer one command from just after an edge and hold it until it is accepted.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 40);
    if (!cmd_ready) begin
      checkOutput("accept_timeout", cmd_ready, 1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Count mid-cycle samples from the accept edge until the controller is ready again.
  task automatic waitIdle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 40);
    if (!cmd_ready) begin
      checkOutput("idle_timeout", cmd_ready, 1);
    end
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
    checkOutput({tag, "_stk_wn"}, stk_wn, 0);
    checkOutput({tag, "_stk_rn"}, stk_rn, 0);
    checkOutput({tag, "_stk_din"}, stk_din, 0);
    checkOutput({tag, "_res_valid"}, res_valid, 0);
    checkOutput({tag, "_res_data"}, res_data, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_depth"}, depth, 0);
  endtask

  // Directed scenarios with hand-computed literal expectations.
  initial begin
    int n;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = OP_PUSH;
    cmd_data    = 8'h00;
    force_full  = 1'b0;
    force_empty = 1'b0;

    resetDut();
    @(negedge clk); #1;
    checkResetValues("reset");

    applyStimulus(OP_PUSH, 8'd5);
    applyStimulus(OP_PUSH, 8'd3);
    applyStimulus(OP_ADD, 8'd0);
    waitIdle(n);
    checkOutput("add_spacing", n, 6);
    checkOutput("add_5_3", last_res, 8'd8);
    checkOutput("add_depth", depth, 1);
    checkOutput("add_err", err, 0);

    resetDut();
    applyStimulus(OP_PUSH, 8'd3);
    applyStimulus(OP_PUSH, 8'd5);
    applyStimulus(OP_SUB, 8'd0);
    waitIdle(n);
    checkOutput("sub_3_5", last_res, 8'hFE);
    applyStimulus(OP_PUSH, 8'hFF);
    applyStimulus(OP_PUSH, 8'h02);
    applyStimulus(OP_ADD, 8'd0);
    waitIdle(n);
    checkOutput("add_wrap", last_res, 8'h01);
    checkOutput("wrap_depth", depth, 2);
    applyStimulus(OP_AND, 8'd0);
    waitIdle(n);
    checkOutput("and_fe_01", last_res, 8'h00);
    applyStimulus(OP_PUSH, 8'hA0);
    applyStimulus(OP_OR, 8'd0);
    waitIdle(n);
    checkOutput("or_00_a0", last_res, 8'hA0);

    resetDut();
    applyStimulus(OP_POP, 8'd0);
    waitIdle(n);
    checkOutput("illegal_pop_spacing", n, 1);
    checkOutput("illegal_pop_err", err, 1);
    checkOutput("illegal_pop_depth", depth, 0);
    applyStimulus(OP_ADD, 8'd0);
    waitIdle(n);
    checkOutput("illegal_add_spacing", n, 1);
    checkOutput("illegal_add_depth", depth, 0);

    resetDut();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(OP_PUSH, 8'(8'h10 + i));
    end
    waitIdle(n);
    checkOutput("full_depth", depth, 8);
    checkOutput("full_err_clear", err, 0);
    applyStimulus(OP_PUSH, 8'hEE);
    waitIdle(n);
    checkOutput("overflow_spacing", n, 1);
    checkOutput("overflow_err", err, 1);
    checkOutput("overflow_depth", depth, 8);
    applyStimulus(OP_DUP, 8'd0);
    waitIdle(n);
    checkOutput("dup_full_spacing", n, 1);
    applyStimulus(OP_POP, 8'd0);
    waitIdle(n);
    checkOutput("pop_spacing", n, 3);
    checkOutput("pop_value", last_res, 8'h17);
    checkOutput("pop_depth", depth, 7);

    resetDut();
    applyStimulus(OP_PUSH, 8'h5A);
    applyStimulus(OP_DUP, 8'd0);
    waitIdle(n);
    checkOutput("dup_spacing", n, 5);
    checkOutput("dup_value", last_res, 8'h5A);
    checkOutput("dup_depth", depth, 2);
    applyStimulus(OP_XOR, 8'd0);
    waitIdle(n);
    checkOutput("xor_self", last_res, 8'h00);
    checkOutput("xor_depth", depth, 1);

    resetDut();
    force_full = 1'b1;
    applyStimulus(OP_PUSH, 8'h11);
    waitIdle(n);
    force_full = 1'b0;
    checkOutput("full_flag_err", err, 1);
    checkOutput("full_flag_depth", depth, 1);
    resetDut();
    applyStimulus(OP_PUSH, 8'h22);
    force_empty = 1'b1;
    applyStimulus(OP_POP, 8'd0);
    waitIdle(n);
    force_empty = 1'b0;
    checkOutput("empty_flag_err", err, 1);
    checkOutput("empty_flag_value", last_res, 8'h22);
    checkOutput("empty_flag_depth", depth, 0);

    resetDut();
    applyStimulus(OP_PUSH, 8'd1);
    applyStimulus(OP_PUSH, 8'd2);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_data  = 8'h00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 40);
    @(posedge clk); #1;
    cmd_op   = OP_PUSH;
    cmd_data = 8'h33;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checkResetValues("midop_reset");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    waitIdle(n);
    checkOutput("post_reset_push_depth", depth, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop so the run always ends even if the controller locks up.
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL global_timeout: simulation did not complete, expected completion before %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
